// File: rtl/up_pkg.sv
// rtl/up_pkg.sv - shared constants for the uP PLC scan engine
// Purpose : opcode encodings, instruction field widths, bit-pin indices and
//           an instruction builder used by the ROM.
// Ports   : none (package).
package up_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;
  localparam int OPR_W   = 12;
  localparam int DATA_W  = 16;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI   = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDA   = 4'h2;
  localparam logic [OPC_W-1:0] OP_LDB   = 4'h3;
  localparam logic [OPC_W-1:0] OP_ANDB  = 4'h4;
  localparam logic [OPC_W-1:0] OP_ORB   = 4'h5;
  localparam logic [OPC_W-1:0] OP_ANDNB = 4'h6;
  localparam logic [OPC_W-1:0] OP_NOTB  = 4'h7;
  localparam logic [OPC_W-1:0] OP_STB   = 4'h8;
  localparam logic [OPC_W-1:0] OP_CMPGE = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'hA;

  localparam logic [1:0] PIN_START = 2'd0;
  localparam logic [1:0] PIN_STOP  = 2'd1;
  localparam logic [1:0] PIN_MOTOR = 2'd2;
  localparam logic [1:0] PIN_MAX   = 2'd3;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [OPC_W-1:0] op,
                                                  input logic [OPR_W-1:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/up_rom.sv
// rtl/up_rom.sv - combinational program ROM holding the pump-station scan
// Purpose : returns ROM[i_addr]; unlisted words decode as NOP.
// Ports   : i_addr  [ROM_AW-1:0] instruction address (PC)
//           o_instr [15:0]       instruction word
// Params  : ROM_AW address width, MAX_PRESSURE over-pressure threshold
//           (only bits [15:4] reach the CMPGE operand).
module up_rom
  import up_pkg::*;
#(
  parameter int          ROM_AW       = 5,
  parameter logic [15:0] MAX_PRESSURE = 16'hC000
) (
  input  logic [ROM_AW-1:0]  i_addr,
  output logic [INSTR_W-1:0] o_instr
);

  always_comb begin
    o_instr = mk_instr(OP_NOP, 12'd0);
    case (int'(i_addr))
      0: o_instr = mk_instr(OP_LDA,   12'd0);
      1: o_instr = mk_instr(OP_CMPGE, MAX_PRESSURE[15:4]);
      2: o_instr = mk_instr(OP_STB,   {10'd0, PIN_MAX});
      // motor = (start | motor) & ~stop & ~max : seal-in with stop/max priority
      3: o_instr = mk_instr(OP_LDB,   {10'd0, PIN_START});
      4: o_instr = mk_instr(OP_ORB,   {10'd0, PIN_MOTOR});
      5: o_instr = mk_instr(OP_ANDNB, {10'd0, PIN_STOP});
      6: o_instr = mk_instr(OP_ANDNB, {10'd0, PIN_MAX});
      7: o_instr = mk_instr(OP_STB,   {10'd0, PIN_MOTOR});
      8: o_instr = mk_instr(OP_JMP,   12'd0);
      default: o_instr = mk_instr(OP_NOP, 12'd0);
    endcase
  end

endmodule

// File: rtl/up.sv
// rtl/up.sv - single-cycle accumulator uP running the pump PLC scan
// Purpose : fetches ROM[PC] combinationally and executes one instruction per
//           rising edge of clk_in in an endless 9-cycle scan.
// Ports   : clk_in  system clock
//           rst_in  synchronous active-high reset
//           a0_io   [15:0] pressure word, input only (driven Z)
//           d0_io   start button, input only (driven Z)
//           d1_io   stop button, input only (driven Z)
//           d2_io   motor output, driven from output latch 2
//           d3_io   max output, driven from output latch 3
// Macro   : UP_WDT_EN adds a 6-bit watchdog that restarts the scan and
//           clears both output latches if no JMP 0 is seen for 63 cycles.
module up
  import up_pkg::*;
#(
  parameter logic [15:0] MAX_PRESSURE = 16'hC000,
  parameter int          ROM_AW       = 5
) (
  input  logic  clk_in,
  input  logic  rst_in,
  inout  wire [15:0] a0_io,
  inout  wire   d0_io,
  inout  wire   d1_io,
  inout  wire   d2_io,
  inout  wire   d3_io
);

  logic [ROM_AW-1:0]  r_pc;
  logic [DATA_W-1:0]  r_acc;
  logic               r_bit;
  logic               r_ol2;
  logic               r_ol3;

  logic [INSTR_W-1:0] w_instr;
  logic [OPC_W-1:0]   w_opcode;
  logic [OPR_W-1:0]   w_operand;
  logic [1:0]         w_n;
  logic               w_dn;
  logic [DATA_W-1:0]  w_cmp_val;

  // Input pads are never driven; outputs always reflect their latches.
  assign a0_io = 16'bz;
  assign d0_io = 1'bz;
  assign d1_io = 1'bz;
  assign d2_io = r_ol2;
  assign d3_io = r_ol3;

  up_rom #(
    .ROM_AW       (ROM_AW),
    .MAX_PRESSURE (MAX_PRESSURE)
  ) u_rom (
    .i_addr  (r_pc),
    .o_instr (w_instr)
  );

  assign w_opcode  = w_instr[INSTR_W-1 -: OPC_W];
  assign w_operand = w_instr[OPR_W-1:0];
  assign w_n       = w_operand[1:0];
  assign w_cmp_val = {w_operand, 4'b0000};

  // Output bits read back their latches, not the pads.
  always_comb begin
    w_dn = 1'b0;
    case (w_n)
      PIN_START: w_dn = d0_io;
      PIN_STOP:  w_dn = d1_io;
      PIN_MOTOR: w_dn = r_ol2;
      PIN_MAX:   w_dn = r_ol3;
      default:   w_dn = 1'b0;
    endcase
  end

`ifdef UP_WDT_EN
  logic [5:0] r_wdt;
  logic       w_jmp0;

  assign w_jmp0 = (w_opcode == OP_JMP) && (w_operand[ROM_AW-1:0] == '0);
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pc  <= '0;
      r_acc <= '0;
      r_bit <= 1'b0;
      r_ol2 <= 1'b0;
      r_ol3 <= 1'b0;
`ifdef UP_WDT_EN
      r_wdt <= '0;
`endif
    end else begin
      r_pc <= r_pc + 1'b1;
      case (w_opcode)
        OP_NOP:   ;
        OP_LDI:   r_acc <= {{(DATA_W-OPR_W){1'b0}}, w_operand};
        OP_LDA:   r_acc <= a0_io;
        OP_LDB:   r_bit <= w_dn;
        OP_ANDB:  r_bit <= r_bit & w_dn;
        OP_ORB:   r_bit <= r_bit | w_dn;
        OP_ANDNB: r_bit <= r_bit & ~w_dn;
        OP_NOTB:  r_bit <= ~r_bit;
        OP_STB: begin
          if (w_n == PIN_MOTOR) r_ol2 <= r_bit;
          if (w_n == PIN_MAX)   r_ol3 <= r_bit;
        end
        OP_CMPGE: r_bit <= (r_acc >= w_cmp_val);
        OP_JMP:   r_pc  <= w_operand[ROM_AW-1:0];
        default:  ;
      endcase
`ifdef UP_WDT_EN
      // Watchdog expiry overrides the PC and output-latch updates of this
      // edge; ACC/BIT effects of the current instruction still take place.
      if (r_wdt == 6'd63) begin
        r_wdt <= '0;
        r_pc  <= '0;
        r_ol2 <= 1'b0;
        r_ol3 <= 1'b0;
      end else if (w_jmp0) begin
        r_wdt <= '0;
      end else begin
        r_wdt <= r_wdt + 6'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_up.sv
// tb/tb_up.sv - directed self-checking bench for the uP scan engine
module tb_up;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] r_press;
  logic        r_start;
  logic        r_stop;

  wire [15:0]  a0;
  wire         d0;
  wire         d1;
  wire         d2;
  wire         d3;

  int n_vec = 0;
  int n_err = 0;

  assign a0 = r_press;
  assign d0 = r_start;
  assign d1 = r_stop;

  always #5 clk_in = ~clk_in;

  up dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .a0_io  (a0),
    .d0_io  (d0),
    .d1_io  (d1),
    .d2_io  (d2),
    .d3_io  (d3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Align to the start of a scan (PC back at 0), bounded.
  task automatic sync_scan();
    int k;
    k = 0;
    while (dut.r_pc !== 5'd0 && k < 20) begin
      tick(1);
      k++;
    end
    check("sync_scan_pc", 16'(dut.r_pc), 16'd0);
  endtask

  // One full scan from PC=0: max latch updates on edge 3, motor on edge 8.
  task automatic scan(input string tag, input logic e3, input logic e2);
    tick(3);
    check({tag, "_d3"}, 16'(d3), 16'(e3));
    tick(5);
    check({tag, "_d2"}, 16'(d2), 16'(e2));
    tick(1);
    check({tag, "_pc"}, 16'(dut.r_pc), 16'd0);
  endtask

  initial begin
    rst_in  = 1'b1;
    r_press = 16'h0000;
    r_start = 1'b0;
    r_stop  = 1'b0;

    // Reset state
    tick(1);
    check("rst_d2", 16'(d2), 16'd0);
    check("rst_d3", 16'(d3), 16'd0);
    check("rst_pc", 16'(dut.r_pc), 16'd0);
    rst_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check("pc_step", 16'(dut.r_pc), 16'(i));
    end
    sync_scan();

    // Over-pressure threshold, inclusive
    r_press = 16'hC000;
    scan("ovp_eq", 1'b1, 1'b0);
    r_press = 16'hBFFF;
    scan("ovp_below", 1'b0, 1'b0);

    // Start seals the motor in
    r_press = 16'h1000;
    r_start = 1'b1;
    scan("start", 1'b0, 1'b1);
    r_start = 1'b0;
    for (int i = 0; i < 6; i++) scan("hold", 1'b0, 1'b1);

    // Stop clears it and it stays off
    r_stop = 1'b1;
    scan("stop", 1'b0, 1'b0);
    r_stop = 1'b0;
    scan("stop_rel", 1'b0, 1'b0);

    // Stop has priority over start
    r_start = 1'b1;
    r_stop  = 1'b1;
    scan("both", 1'b0, 1'b0);
    r_stop  = 1'b0;
    scan("restart", 1'b0, 1'b1);
    r_start = 1'b0;
    scan("restart_hold", 1'b0, 1'b1);

    // Over-pressure trip
    r_press = 16'hFFFF;
    scan("trip", 1'b1, 1'b0);
    r_press = 16'h0000;
    scan("trip_clr", 1'b0, 1'b0);
    scan("trip_off", 1'b0, 1'b0);

    // Mid-scan reset discards latches and restarts at address 0
    r_start = 1'b1;
    scan("pre_rst", 1'b0, 1'b1);
    r_start = 1'b0;
    tick(4);
    rst_in = 1'b1;
    tick(1);
    check("mid_rst_d2", 16'(d2), 16'd0);
    check("mid_rst_d3", 16'(d3), 16'd0);
    check("mid_rst_pc", 16'(dut.r_pc), 16'd0);
    rst_in = 1'b0;
    tick(1);
    check("mid_rst_pc1", 16'(dut.r_pc), 16'd1);
    sync_scan();
    scan("post_rst", 1'b0, 1'b0);

`ifdef UP_WDT_EN
    // With the regular JMP 0 every scan the watchdog never gets close to expiry.
    r_start = 1'b1;
    scan("wdt_start", 1'b0, 1'b1);
    r_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("wdt_low", 16'(dut.r_wdt <= 6'd9), 16'd1);
    end
    sync_scan();
    scan("wdt_hold", 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
